// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle load/store stage between the core datapath and a word-wide
//   data memory bus with a valid/ready handshake. It handles RV32I byte,
//   halfword and word accesses: store lane steering and write strobes, load
//   sign/zero extension, misalignment and illegal-funct3 detection, and a
//   bus timeout.
//
//   State table:
//     IDLE | waiting for req_valid; a request is decoded and latched here
//     REQ  | bus request outstanding, waiting for mem_ready or timeout
//     DONE | result captured; done/rdata/err are published on leaving
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   req_valid/we/funct3   core access request (held by core until done)
//   req_addr, req_wdata   byte address and store data (rs2)
//   busy                  access in flight, core stalls
//   done, rdata, err      one-cycle completion pulse, result, error flag
//   mem_req/we/addr       word-aligned bus request
//   mem_wstrb, mem_wdata  byte strobes and lane-steered store data
//   mem_ready, mem_rdata  bus completion and read word
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              lat_we, lat_we_nx;
  logic [2:0]        lat_f3, lat_f3_nx;
  logic [1:0]        lat_off, lat_off_nx;
  logic [31:0]       res_data, res_data_nx;
  logic              res_err, res_err_nx;
  logic              done_nx, err_nx;
  logic [31:0]       rdata_nx;
  logic              mem_req_nx, mem_we_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [3:0]        mem_wstrb_nx;
  logic [31:0]       mem_wdata_nx;

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Only called for legal funct3, so the size field alone decides alignment.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] w);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{w[7:0]}};
      2'b01:   d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    lat_we_nx    = lat_we;
    lat_f3_nx    = lat_f3;
    lat_off_nx   = lat_off;
    res_data_nx  = res_data;
    res_err_nx   = res_err;
    done_nx      = 1'b0;
    rdata_nx     = rdata;
    err_nx       = err;
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wstrb_nx = mem_wstrb;
    mem_wdata_nx = mem_wdata;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          lat_we_nx  = req_we;
          lat_f3_nx  = req_funct3;
          lat_off_nx = req_addr[1:0];
          if (is_legal(req_we, req_funct3) && is_aligned(req_funct3[1:0], req_addr[1:0])) begin
            state_nx     = REQ;
            cnt_nx       = '0;
            mem_req_nx   = 1'b1;
            mem_we_nx    = req_we;
            mem_addr_nx  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wstrb_nx = req_we ? store_strb(req_funct3[1:0], req_addr[1:0]) : 4'b0000;
            mem_wdata_nx = req_we ? store_data(req_funct3[1:0], req_wdata) : 32'b0;
          end else begin
            state_nx    = DONE;
            res_err_nx  = 1'b1;
            res_data_nx = '0;
          end
        end
      end
      REQ: begin
        // mem_ready wins over a timeout landing in the same cycle.
        if (mem_ready || (TIMEOUT != 0 && cnt == CNT_LIMIT)) begin
          state_nx     = DONE;
          res_err_nx   = ~mem_ready;
          res_data_nx  = (mem_ready && !lat_we) ? load_extend(lat_f3, lat_off, mem_rdata) : 32'b0;
          mem_req_nx   = 1'b0;
          mem_we_nx    = 1'b0;
          mem_addr_nx  = '0;
          mem_wstrb_nx = '0;
          mem_wdata_nx = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        done_nx  = 1'b1;
        rdata_nx = res_data;
        err_nx   = res_err;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_f3    <= '0;
      lat_off   <= '0;
      res_data  <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      lat_we    <= lat_we_nx;
      lat_f3    <= lat_f3_nx;
      lat_off   <= lat_off_nx;
      res_data  <= res_data_nx;
      res_err   <= res_err_nx;
      busy      <= (state_nx != IDLE);
      done      <= done_nx;
      rdata     <= rdata_nx;
      err       <= err_nx;
      mem_req   <= mem_req_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wstrb <= mem_wstrb_nx;
      mem_wdata <= mem_wdata_nx;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Drives directed and random accesses into load_store_unit while acting as
//   the memory. Expected outputs for every cycle come from a behavioural model
//   of the access rules; a negedge process compares them against the DUT.
module tb_load_store_unit;

  localparam int ADDR_W    = 32;
  localparam int TIMEOUT_P = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              busy, done, err, mem_req, mem_we;
  logic [31:0]       rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic              mem_ready = 1'b0;
  logic [31:0]       mem_rdata = '0;

  // model expectations
  logic              exp_busy = 0, exp_done = 0, exp_err = 0, exp_req = 0, exp_we = 0;
  logic [31:0]       exp_rdata = 0, exp_wdata = 0;
  logic [ADDR_W-1:0] exp_addr = 0;
  logic [3:0]        exp_wstrb = 0;

  // bus observations used by literal checks
  int                req_hi = 0;
  logic [3:0]        seen_wstrb = 0;
  logic [31:0]       seen_wdata = 0;
  logic [ADDR_W-1:0] seen_addr = 0;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT_P)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_legal(input bit we, input logic [2:0] f3);
    int f = int'(f3);
    if (we) return f <= 2;
    return f <= 2 || f == 4 || f == 5;
  endfunction

  function automatic int m_bytes(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % m_bytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] addr);
    int mask = (1 << m_bytes(f3)) - 1;
    return 4'(mask << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (m_bytes(f3))
      1:       return (w & 32'hFF) * 32'h01010101;
      2:       return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] word);
    logic [31:0] v = word >> (8 * (addr % 4));
    case (int'(f3))
      0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
      1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
      4: v = v & 32'hFF;
      5: v = v & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
    check("rdata", rdata, exp_rdata);
    check("err", 32'(err), 32'(exp_err));
    check("mem_req", 32'(mem_req), 32'(exp_req));
    check("mem_we", 32'(mem_we), 32'(exp_we));
    check("mem_addr", mem_addr, exp_addr);
    check("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
    if (!(exp_req && !exp_we)) check("mem_wdata", mem_wdata, exp_wdata);
    if (mem_req) begin
      req_hi++;
      seen_addr = mem_addr;
      if (mem_we) begin
        seen_wstrb = mem_wstrb;
        seen_wdata = mem_wdata;
      end
    end
  end

  // Called at posedge+1 with the DUT idle. waits = REQ cycles with
  // mem_ready low before it rises; large values force a timeout.
  task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rword, input int waits);
    bit          ok, got;
    int          i;
    logic [31:0] res;
    req_hi     = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    ok = m_legal(we, f3) && m_aligned(f3, addr);
    @(posedge clk); #1;
    // core keeps req_valid high; the rest must already be latched
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    exp_busy   = 1'b1;
    res        = '0;
    got        = 1'b0;
    if (ok) begin
      exp_req   = 1'b1;
      exp_we    = we;
      exp_addr  = addr & ~32'h3;
      exp_wstrb = we ? m_strb(f3, addr) : 4'b0000;
      exp_wdata = we ? m_wdata(f3, wdata) : 32'h0;
      for (i = 0; i < 64; i++) begin
        mem_ready = (i == waits);
        mem_rdata = mem_ready ? rword : $urandom;
        @(posedge clk); #1;
        if (i == waits) begin
          got = 1'b1;
          break;
        end
        if (i == TIMEOUT_P - 1) break;
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (got && !we) res = m_load(f3, addr, rword);
      exp_req   = 1'b0;
      exp_we    = 1'b0;
      exp_addr  = '0;
      exp_wstrb = '0;
      exp_wdata = '0;
    end
    @(posedge clk); #1;
    exp_busy  = 1'b0;
    exp_done  = 1'b1;
    exp_rdata = res;
    exp_err   = !(ok && got);
    req_valid = 1'b0;
    @(posedge clk); #1;
    exp_done  = 1'b0;
  endtask

  initial begin
    int r;
    logic [2:0] f3;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // zero-wait loads with sign and zero extension
    txn(0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 0);
    check("lb_addr", seen_addr, 32'h100);
    check("lb_rdata", rdata, 32'hFFFFFF80);
    check("lb_req_cycles", req_hi, 1);
    txn(0, 3'b100, 32'h103, 32'h0, 32'h80AABBCC, 0);
    check("lbu_rdata", rdata, 32'h00000080);

    // stores
    txn(1, 3'b001, 32'h206, 32'h1234ABCD, 32'h0, 1);
    check("sh_wstrb", 32'(seen_wstrb), 32'hC);
    check("sh_wdata", seen_wdata, 32'hABCDABCD);
    check("sh_rdata", rdata, 32'h0);
    txn(1, 3'b000, 32'h201, 32'h00000055, 32'h0, 0);
    check("sb_wstrb", 32'(seen_wstrb), 32'h2);
    check("sb_wdata", seen_wdata, 32'h55555555);

    // misaligned / illegal: no bus request at all
    txn(0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    check("lw_mis_err", 32'(err), 32'h1);
    check("lw_mis_req", req_hi, 0);
    txn(0, 3'b001, 32'h101, 32'h0, 32'h0, 0);
    check("lh_mis_req", req_hi, 0);
    txn(1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    check("st_ill_err", 32'(err), 32'h1);
    check("st_ill_req", req_hi, 0);

    // wait states
    txn(0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 3);
    check("lw_wait_rdata", rdata, 32'hDEADBEEF);
    check("lw_wait_req_cycles", req_hi, 4);

    // timeout, and ready on the last allowed cycle
    txn(0, 3'b010, 32'h80, 32'h0, 32'h11111111, 1000);
    check("to_req_cycles", req_hi, 16);
    check("to_err", 32'(err), 32'h1);
    check("to_rdata", rdata, 32'h0);
    txn(0, 3'b010, 32'h80, 32'h0, 32'h22222222, 15);
    check("last_req_cycles", req_hi, 16);
    check("last_err", 32'(err), 32'h0);
    check("last_rdata", rdata, 32'h22222222);

    // reset two cycles into a waiting REQ
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h80;
    @(posedge clk); #1;
    exp_busy = 1'b1;
    exp_req  = 1'b1;
    exp_addr = 32'h80;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    exp_busy  = 0; exp_req = 0; exp_addr = 0; exp_we = 0; exp_wstrb = 0; exp_wdata = 0;
    exp_rdata = 0; exp_err = 0; exp_done = 0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    txn(0, 3'b101, 32'h32, 32'h0, 32'h9876F00D, 1);
    check("post_rst_rdata", rdata, 32'h00009876);

    // random traffic
    for (int k = 0; k < 120; k++) begin
      r  = int'($urandom_range(0, 9));
      f3 = 3'($urandom);
      txn(1'($urandom), f3, $urandom, $urandom, $urandom,
          (r < 7) ? r % 4 : (r == 7) ? 15 : (r == 8) ? 16 + r : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store stage between the core datapath (ALU address, register read-data 2, writeback result mux) and a word-wide data memory bus with a valid/ready handshake.
- Handles byte, halfword and word accesses per RV32I funct3: byte-lane steering, write strobes, load sign/zero extension and misalignment detection.
- Replaces the direct single-cycle data memory hookup so slow memories can insert wait states; the core stalls while `busy` is high.

Parameters:
ADDR_W  32  width of byte address on core and memory sides
TIMEOUT  16  max cycles waiting for mem_ready before error; 0 disables timeout

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  core requests an access (held until done)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  ADDR_W  byte address from ALU
req_wdata  input  32  store data (rs2)
busy  output  1  state != IDLE; core stalls PC/regfile write
done  output  1  one-cycle pulse, access complete
rdata  output  32  extended load result, valid with done, held until next done
err  output  1  valid with done: misaligned, illegal funct3 or timeout
mem_req  output  1  bus request
mem_we  output  1  bus write enable
mem_addr  output  ADDR_W  word-aligned address (req_addr with [1:0] = 0)
mem_wstrb  output  4  byte write strobes (0000 on loads)
mem_wdata  output  32  lane-steered store data
mem_ready  input  1  memory completes the request this cycle
mem_rdata  input  32  read word, valid when mem_ready

Behaviour:
- All outputs are registered.
- Reset (async, any state): state=IDLE; every output = 0; timeout counter = 0. Asserting reset mid-REQ drops mem_req immediately and produces no done.

FSM: IDLE, REQ, DONE.
- IDLE, req_valid=1 at clock edge:
  - Latch we, funct3, addr, wdata.
  - Legal and aligned access: go to REQ with mem_req=1 and bus fields driven.
  - Otherwise: go to DONE with err=1, rdata=0, and no bus request.
- Legality:
  - Loads: funct3 ∈ {000, 001, 010, 100, 101}.
  - Stores: funct3 ∈ {000, 001, 010}.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Byte is always aligned.
- REQ:
  - mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata stay stable until mem_ready is sampled high.
  - On mem_ready=1: capture/extend mem_rdata (loads), drop mem_req, go to DONE with err=0.
  - Timeout counter increments each REQ cycle without ready. If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with mem_ready=0: drop mem_req, go to DONE with err=1, rdata=0.
  - mem_ready in the same cycle as the timeout limit takes priority (success).
- DONE: done=1 for exactly one cycle, then IDLE. Counter clears.
- req_valid is ignored outside IDLE. A request still high in the cycle after DONE is accepted as a new access; the core must deassert req_valid on done.
- Latency: accept edge N → mem_req high after N → earliest done at N+2 (zero-wait memory). Each wait state adds 1 cycle. Error path: done at N+1.
- Stores:
  - SB: mem_wstrb = 0001 << addr[1:0]; wdata[7:0] replicated to all 4 lanes.
  - SH: mem_wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1); wdata[15:0] replicated to both halves.
  - SW: mem_wstrb = 1111; wdata passed through.
- Loads:
  - Byte lane selected by addr[1:0]; halfword selected by addr[1].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes through.
  - Stores complete with rdata=0.
- mem_addr, mem_wstrb and mem_wdata return to 0 when mem_req is low.

Test Plan:
- LB, addr=0x103, mem_rdata=0x80AABBCC, zero wait → mem_addr=0x100, done at accept+2, rdata=0xFFFFFF80, err=0; LBU same → rdata=0x00000080.
- SH, addr=0x206, wdata=0x1234ABCD → mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1; SB, addr=0x201, wdata=0x55 → mem_wstrb=0010, mem_wdata=0x55555555.
- Misaligned and illegal requests → done one cycle after accept, err=1, mem_req never asserted:
  - LW addr=0x102
  - LH addr=0x101
  - store with funct3=100
- LW, addr=0x40, mem_ready held low 3 cycles then high with mem_rdata=0xDEADBEEF → busy high throughout, bus fields stable, done at accept+5, rdata=0xDEADBEEF.
- TIMEOUT=16, mem_ready never high → mem_req drops after 16 REQ cycles, done with err=1, rdata=0. Same run with ready at cycle 16 → success.
- Reset asserted two cycles into a waiting REQ → mem_req and busy go 0 without a clock edge, no done. First request after reset release completes normally.
